// File: rtl/instruction_prefetch_queue.sv
// rtl/instruction_prefetch_queue.sv - dword code fetcher feeding a circular byte queue with a 16-byte decode window
module instruction_prefetch_queue #(
    parameter int          QUEUE_BYTES   = 16,
    parameter logic [31:0] RESET_ADDRESS = 32'hFFFF_FFF0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] flush_address,
    output logic        bus_read_vaild,
    input  logic        bus_read_ready,
    output logic [31:0] bus_read_address,
    input  logic [31:0] bus_read_data,
    output logic [7:0]  instruction [0:15],
    output logic [4:0]  bytes_valid,
    input  logic        consume,
    input  logic [4:0]  consume_count
);

    localparam int PW  = $clog2(QUEUE_BYTES);
    localparam int CW  = PW + 1;
    localparam int CW1 = CW + 1;

    typedef enum logic [1:0] {REDIRECT, IDLE, REQ} state_t;

    state_t          state;
    logic [7:0]      queue_mem [QUEUE_BYTES];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic [31:0]     fetch_address;

    logic [2:0]      enq_size;
    logic [4:0]      retire;
    logic            transfer;
    logic [CW-1:0]   count_after_consume;
    logic [CW-1:0]   count_next;
    logic            room_for_fetch;
    logic            room_after_transfer;
    logic [31:0]     shifted_data;
    logic [31:0]     next_fetch_address;

    // A misaligned first fetch after a redirect only delivers the upper bytes of its dword.
    assign enq_size            = 3'd4 - {1'b0, fetch_address[1:0]};
    assign shifted_data        = bus_read_data >> {fetch_address[1:0], 3'b000};
    assign retire              = !consume ? 5'd0 :
                                 (consume_count > bytes_valid) ? bytes_valid : consume_count;
    assign transfer            = bus_read_vaild && bus_read_ready;
    assign count_after_consume = count - CW'(retire);
    assign count_next          = count_after_consume + (transfer ? CW'(enq_size) : CW'(0));
    assign room_for_fetch      = ({1'b0, count_after_consume} + CW1'(enq_size)) <= CW1'(QUEUE_BYTES);
    assign room_after_transfer = ({1'b0, count_next} + CW1'(4)) <= CW1'(QUEUE_BYTES);
    assign next_fetch_address  = {bus_read_address[31:2] + 30'd1, 2'b00};

    assign bytes_valid = (count > CW'(16)) ? 5'd16 : count[4:0];

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            instruction[i] = (5'(i) < bytes_valid) ? queue_mem[head + PW'(i)] : 8'h00;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && !flush && transfer) begin
            for (int j = 0; j < 4; j++) begin
                if (3'(j) < enq_size) begin
                    queue_mem[tail + PW'(j)] <= shifted_data[8*j +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= REDIRECT;
            fetch_address    <= RESET_ADDRESS;
            bus_read_address <= {RESET_ADDRESS[31:2], 2'b00};
            bus_read_vaild   <= 1'b0;
            head             <= '0;
            tail             <= '0;
            count            <= '0;
        end else if (flush) begin
            state            <= REDIRECT;
            fetch_address    <= flush_address;
            bus_read_address <= {flush_address[31:2], 2'b00};
            bus_read_vaild   <= 1'b0;
            head             <= '0;
            tail             <= '0;
            count            <= '0;
        end else begin
            head  <= head + PW'(retire);
            count <= count_next;
            if (transfer) begin
                tail             <= tail + PW'(enq_size);
                fetch_address    <= next_fetch_address;
                bus_read_address <= next_fetch_address;
            end
            case (state)
                REDIRECT, IDLE: begin
                    if (room_for_fetch) begin
                        state          <= REQ;
                        bus_read_vaild <= 1'b1;
                    end else begin
                        state          <= IDLE;
                        bus_read_vaild <= 1'b0;
                    end
                end
                REQ: begin
                    // Without ready the request is held; with ready, keep streaming only if a full dword still fits.
                    if (transfer && !room_after_transfer) begin
                        state          <= IDLE;
                        bus_read_vaild <= 1'b0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    bus_read_vaild <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// tb/tb_instruction_prefetch_queue.sv - directed and randomized check of the prefetch queue against a byte-queue model
module tb_instruction_prefetch_queue;

    localparam int Q = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] flush_address = 32'h0;
    logic        bus_read_vaild;
    logic        bus_read_ready = 1'b0;
    logic [31:0] bus_read_address;
    logic [31:0] bus_read_data = 32'h0;
    logic [7:0]  instruction [0:15];
    logic [4:0]  bytes_valid;
    logic        consume = 1'b0;
    logic [4:0]  consume_count = 5'd0;

    always #5 clock = ~clock;

    instruction_prefetch_queue #(.QUEUE_BYTES(Q), .RESET_ADDRESS(32'hFFFF_FFF0)) dut (
        .clock(clock),
        .reset(reset),
        .flush(flush),
        .flush_address(flush_address),
        .bus_read_vaild(bus_read_vaild),
        .bus_read_ready(bus_read_ready),
        .bus_read_address(bus_read_address),
        .bus_read_data(bus_read_data),
        .instruction(instruction),
        .bytes_valid(bytes_valid),
        .consume(consume),
        .consume_count(consume_count)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0]  mq [$];
    logic [31:0] m_fetch;
    bit          m_req;

    task automatic model_edge();
        int n, k, bv;
        logic [31:0] sh;
        if (reset) begin
            mq.delete();
            m_fetch = 32'hFFFF_FFF0;
            m_req   = 1'b0;
        end else if (flush) begin
            mq.delete();
            m_fetch = flush_address;
            m_req   = 1'b0;
        end else begin
            n  = 4 - int'(m_fetch[1:0]);
            bv = (mq.size() > 16) ? 16 : mq.size();
            k  = consume ? ((int'(consume_count) < bv) ? int'(consume_count) : bv) : 0;
            repeat (k) void'(mq.pop_front());
            if (m_req && bus_read_ready) begin
                sh = bus_read_data >> (8 * (4 - n));
                for (int j = 0; j < n; j++) mq.push_back(sh[8*j +: 8]);
                m_fetch = {m_fetch[31:2], 2'b00} + 32'd4;
                m_req   = (Q - mq.size()) >= 4;
            end else if (!m_req) begin
                m_req = (Q - mq.size()) >= n;
            end
        end
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [127:0] obs_w, exp_w;
        int bv;
        bv = (mq.size() > 16) ? 16 : mq.size();
        for (int i = 0; i < 16; i++) begin
            obs_w[8*i +: 8] = instruction[i];
            exp_w[8*i +: 8] = (i < bv) ? mq[i] : 8'h00;
        end
        check("vaild", 128'(bus_read_vaild), 128'(m_req));
        check("address", 128'(bus_read_address), 128'({m_fetch[31:2], 2'b00}));
        check("bytes_valid", 128'(bytes_valid), 128'(bv));
        check("window", obs_w, exp_w);
    endtask

    task automatic step(input bit r, input bit f, input logic [31:0] fa, input bit rdy,
                        input logic [31:0] d, input bit c, input logic [4:0] cc);
        reset          = r;
        flush          = f;
        flush_address  = fa;
        bus_read_ready = rdy;
        bus_read_data  = d;
        consume        = c;
        consume_count  = cc;
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_all();
    endtask

    initial begin
        logic [7:0] prev2;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 32'h1234_5678, 0, 0);
        check("reset_address", 128'(bus_read_address), 128'(32'hFFFF_FFF0));
        check("reset_vaild", 128'(bus_read_vaild), 128'(0));

        // 1: first request and transfer
        step(0, 0, 0, 0, 0, 0, 0);
        check("t1_vaild", 128'(bus_read_vaild), 128'(1));
        step(0, 0, 0, 1, 32'h4433_2211, 0, 0);
        check("t1_bytes", 128'(bytes_valid), 128'(4));
        check("t1_byte0", 128'(instruction[0]), 128'(8'h11));
        check("t1_byte3", 128'(instruction[3]), 128'(8'h44));
        check("t1_next", 128'(bus_read_address), 128'(32'hFFFF_FFF4));

        // 2: fill, stall, resume
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, $urandom, 0, 0);
        check("t2_full", 128'(bytes_valid), 128'(16));
        check("t2_stall", 128'(bus_read_vaild), 128'(0));
        step(0, 0, 0, 1, $urandom, 1, 5'd3);
        check("t2_still_idle", 128'(bus_read_vaild), 128'(0));
        step(0, 0, 0, 0, 0, 1, 5'd1);
        step(0, 0, 0, 0, 0, 0, 0);
        check("t2_resume", 128'(bus_read_vaild), 128'(1));

        // 3: misaligned redirect
        step(0, 1, 32'h0000_1003, 1, $urandom, 1, 5'd2);
        check("t3_redirect_vaild", 128'(bus_read_vaild), 128'(0));
        step(0, 0, 0, 0, 0, 0, 0);
        check("t3_address", 128'(bus_read_address), 128'(32'h0000_1000));
        step(0, 0, 0, 1, 32'hDDCC_BBAA, 0, 0);
        check("t3_bytes", 128'(bytes_valid), 128'(1));
        check("t3_byte0", 128'(instruction[0]), 128'(8'hDD));
        check("t3_byte1", 128'(instruction[1]), 128'(8'h00));

        // 4: enqueue and consume together
        step(0, 0, 0, 1, $urandom, 0, 0);
        step(0, 0, 0, 1, $urandom, 0, 0);
        step(0, 0, 0, 1, $urandom, 1, 5'd3);
        check("t4_ten", 128'(bytes_valid), 128'(10));
        prev2 = instruction[2];
        step(0, 0, 0, 1, $urandom, 1, 5'd2);
        check("t4_twelve", 128'(bytes_valid), 128'(12));
        check("t4_shift", 128'(instruction[0]), 128'(prev2));

        // 5: flush beats ready and consume
        step(0, 1, 32'h0000_2006, 1, $urandom, 1, 5'd4);
        check("t5_empty", 128'(bytes_valid), 128'(0));
        step(0, 0, 0, 0, 0, 0, 0);
        check("t5_req", 128'(bus_read_address), 128'(32'h0000_2004));

        // 6: address wrap, then reset during a transfer
        step(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, $urandom, 0, 0);
        check("t6_wrap", 128'(bus_read_address), 128'(32'h0000_0000));
        step(1, 0, 0, 1, $urandom, 1, 5'd1);
        check("t6_reset_bytes", 128'(bytes_valid), 128'(0));
        check("t6_reset_addr", 128'(bus_read_address), 128'(32'hFFFF_FFF0));

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0), $urandom,
                 ($urandom_range(0, 2) != 0), $urandom, $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 31)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
